adam_mem_banked: RTL
====================

Name: adam_mem_banked

Overview:
Multi-port, word-interleaved banked on-chip SRAM with per-byte DIFT tag storage. It is the generalised successor of the single-port scratchpad.
- NO_PORTS masters each issue req/gnt requests into NO_BANKS independent single-access banks.
- Round-robin arbitration is performed per bank; read data returns with a one-cycle rvalid.
- Sits behind the bus/crossbar as the main tagged memory for cores and DMA.

Parameters:
ADAM_CFG_PARAMS, (codebase default), supplies ADDR_WIDTH, DATA_WIDTH, STRB_WIDTH, ADDR_T, DATA_T, STRB_T
SIZE, 4096, total bytes; must be a multiple of STRB_WIDTH*NO_BANKS
NO_PORTS, 2, number of requesting ports (>=1)
NO_BANKS, 2, number of banks; power of two (>=1)
HEXFILE, "", simulation-only data preload (whole memory, linear word order)
TAG_HEXFILE, "", simulation-only tag preload (one STRB_WIDTH-bit tag word per data word)

Ports:
seq.clk  in  1  clock (ADAM_SEQ.Slave seq); one clock
seq.rst  in  1  reset, asynchronous, active-low (ADAM_SEQ.Slave seq)
req  in  [NO_PORTS]  request valid per port
gnt  out  [NO_PORTS]  request accepted this cycle (combinational from req/addr)
addr  in  [NO_PORTS] ADDR_T  byte address
we  in  [NO_PORTS]  data write enable
be  in  [NO_PORTS] STRB_T  byte strobes (data and tag)
wdata  in  [NO_PORTS] DATA_T  write data
we_tag  in  [NO_PORTS]  tag write enable
wdata_tag  in  [NO_PORTS]  tag bit written to every strobed byte
rvalid  out  [NO_PORTS]  response valid, one cycle after gnt
rdata  out  [NO_PORTS] DATA_T  read data
rdata_tag  out  [NO_PORTS] STRB_WIDTH  per-byte tag bits

Behaviour:
- Address decode:
  - word = addr >> log2(STRB_WIDTH).
  - bank = word[log2(NO_BANKS)-1:0].
  - row = next bits, modulo SIZE/(STRB_WIDTH*NO_BANKS).
  - Upper address bits are ignored, so accesses wrap.
- Arbitration, per bank, each cycle:
  - Among ports with req=1 targeting that bank, grant the first port at or after rr_ptr[bank], searching cyclically.
  - A bank grants at most one port per cycle. Ports on different banks are granted in the same cycle.
  - On a grant, rr_ptr[bank] <= winner+1 (mod NO_PORTS). With no grant, the pointer holds.
- Handshake:
  - gnt is combinational.
  - A port without gnt must hold req, addr, we, be, wdata, we_tag and wdata_tag stable until granted.
  - req may drop only after gnt.
- Access, at the posedge where gnt[p]=1:
  - For each i with be[i]=1: if we, data byte i is written; if we_tag, tag bit i <= wdata_tag.
  - The read is read-before-write: rdata and rdata_tag return the pre-write word.
  - be=0 writes nothing but still returns a response.
- Latency: rvalid[p]=1 exactly one cycle after each gnt[p]=1, carrying that access's data. Back-to-back grants give back-to-back rvalid.
- rdata and rdata_tag hold their last value while rvalid=0.
- Reset:
  - Asynchronous assertion forces rvalid=0, rdata=0, rdata_tag=0 and all rr_ptr=0.
  - Memory and tag arrays are not reset.
  - No write occurs while reset is asserted.
  - An access granted in the reset cycle is lost, with no response.
- Simulation only: HEXFILE and TAG_HEXFILE are loaded via $readmemh into linear word order, then distributed to banks.
- Elaboration errors: SIZE not a multiple of STRB_WIDTH*NO_BANKS, or NO_BANKS not a power of two.

Decomposition:
- adam_mem_pkg holds the helper functions bank_of(addr) and row_of(addr) and the localparams UNALIGNED_WIDTH, BANK_WIDTH, ROW_WIDTH and ROWS.
- Sub-module adam_mem_bank: one bank, i.e. a block-RAM data array plus a STRB_WIDTH-bit tag array, one port, byte-strobed writes, 1-cycle registered read-before-write.
- Arbitration, the rr pointers and the response/valid pipeline stay in the top level.

Test Plan:
(Bench: DATA_WIDTH=32, STRB_WIDTH=4, NO_PORTS=2, NO_BANKS=2; bank=addr[2].)
1. Single write then read: P0 writes 0xDEADBEEF to 0x10, be=0xF; P0 reads 0x10 -> gnt same cycle, rvalid next cycle, rdata=0xDEADBEEF.
2. Bank conflict after reset: P0 at 0x00 and P1 at 0x08 both req -> gnt=01 in cycle 0, gnt=10 in cycle 1; a second simultaneous conflict -> P1 not favoured twice, P0 granted first again.
3. No conflict: P0 at 0x00 and P1 at 0x04 -> gnt=11 in the same cycle, both rvalid the next cycle with the correct data.
4. Strobes and tags: word zeroed; write 0x11223344, be=0b0101, we=1, we_tag=1, wdata_tag=1 -> readback rdata=0x00220044, rdata_tag=0b0101.
5. Read-before-write: word holds 0xAAAA5555; write 0x12345678 -> rdata in that response=0xAAAA5555; next read returns 0x12345678.
6. Reset mid-traffic: assert seq.rst low during conflicting requests -> rvalid=0 immediately; after release, conflict on bank 0 grants P0 first (rr_ptr=0).

Source files
------------

// File: rtl/adam_mem_pkg.sv
// Shared address-decode helpers and default geometry for the banked memory.
package adam_mem_pkg;

  localparam int unsigned DEF_ADDR_WIDTH = 32;
  localparam int unsigned DEF_DATA_WIDTH = 32;
  localparam int unsigned DEF_STRB_WIDTH = DEF_DATA_WIDTH / 8;
  localparam int unsigned DEF_SIZE       = 4096;
  localparam int unsigned DEF_NO_BANKS   = 2;

  localparam int unsigned UNALIGNED_WIDTH = $clog2(DEF_STRB_WIDTH);
  localparam int unsigned BANK_WIDTH      = (DEF_NO_BANKS > 1) ? $clog2(DEF_NO_BANKS) : 1;
  localparam int unsigned ROWS            = DEF_SIZE / (DEF_STRB_WIDTH * DEF_NO_BANKS);
  localparam int unsigned ROW_WIDTH       = (ROWS > 1) ? $clog2(ROWS) : 1;

  // Word-interleaved: the low word-address bits select the bank.
  function automatic int unsigned bank_of(input logic [63:0] addr,
                                          input int unsigned unaligned_w,
                                          input int unsigned no_banks);
    logic [63:0] word;
    word = addr >> unaligned_w;
    return 32'(word % 64'(no_banks));
  endfunction

  // Remaining word-address bits select the row; upper bits wrap.
  function automatic int unsigned row_of(input logic [63:0] addr,
                                         input int unsigned unaligned_w,
                                         input int unsigned no_banks,
                                         input int unsigned rows);
    logic [63:0] word;
    word = (addr >> unaligned_w) / 64'(no_banks);
    return 32'(word % 64'(rows));
  endfunction

endpackage

// File: rtl/adam_mem_bank.sv
// One memory bank: data array plus per-byte tag array, single port,
// byte-strobed writes, registered read-before-write.
module adam_mem_bank #(
  parameter int unsigned ROWS       = 512,
  parameter int unsigned ROW_W      = 9,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic [ROW_W-1:0]      row,
  input  logic                  we,
  input  logic [STRB_WIDTH-1:0] be,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  we_tag,
  input  logic                  wdata_tag,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic [STRB_WIDTH-1:0] rdata_tag
);

  logic [DATA_WIDTH-1:0] mem [ROWS];
  logic [STRB_WIDTH-1:0] tag [ROWS];

  // Read old contents and apply strobed data/tag writes on the same edge.
  always_ff @(posedge clk) begin
    if (en) begin
      rdata     <= mem[row];
      rdata_tag <= tag[row];
      for (int i = 0; i < STRB_WIDTH; i++) begin
        if (be[i]) begin
          if (we)     mem[row][i*8 +: 8] <= wdata[i*8 +: 8];
          if (we_tag) tag[row][i]        <= wdata_tag;
        end
      end
    end
  end

endmodule

// File: rtl/adam_mem_banked.sv
// Multi-port word-interleaved banked SRAM with per-byte tags. Per-bank
// round-robin arbitration, one-cycle response with held read data.
module adam_mem_banked
  import adam_mem_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned STRB_WIDTH = DATA_WIDTH / 8,
  parameter int unsigned SIZE       = DEF_SIZE,
  parameter int unsigned NO_PORTS   = 2,
  parameter int unsigned NO_BANKS   = DEF_NO_BANKS
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [NO_PORTS-1:0]                  req,
  output logic [NO_PORTS-1:0]                  gnt,
  input  logic [NO_PORTS-1:0][ADDR_WIDTH-1:0]  addr,
  input  logic [NO_PORTS-1:0]                  we,
  input  logic [NO_PORTS-1:0][STRB_WIDTH-1:0]  be,
  input  logic [NO_PORTS-1:0][DATA_WIDTH-1:0]  wdata,
  input  logic [NO_PORTS-1:0]                  we_tag,
  input  logic [NO_PORTS-1:0]                  wdata_tag,
  output logic [NO_PORTS-1:0]                  rvalid,
  output logic [NO_PORTS-1:0][DATA_WIDTH-1:0]  rdata,
  output logic [NO_PORTS-1:0][STRB_WIDTH-1:0]  rdata_tag
);

  localparam int unsigned UA_W   = $clog2(STRB_WIDTH);
  localparam int unsigned ROWS_L = SIZE / (STRB_WIDTH * NO_BANKS);
  localparam int unsigned ROW_W  = (ROWS_L > 1) ? $clog2(ROWS_L) : 1;
  localparam int unsigned BANK_W = (NO_BANKS > 1) ? $clog2(NO_BANKS) : 1;
  localparam int unsigned PORT_W = (NO_PORTS > 1) ? $clog2(NO_PORTS) : 1;

  if ((SIZE % (STRB_WIDTH * NO_BANKS)) != 0) begin : g_bad_size
    $error("adam_mem_banked: SIZE must be a multiple of STRB_WIDTH*NO_BANKS");
  end
  if ((NO_BANKS & (NO_BANKS - 1)) != 0) begin : g_bad_banks
    $error("adam_mem_banked: NO_BANKS must be a power of two");
  end

  logic [NO_PORTS-1:0][BANK_W-1:0]   tgt_bank;
  logic [NO_PORTS-1:0][ROW_W-1:0]    tgt_row;
  logic [NO_BANKS-1:0][PORT_W-1:0]   rr_ptr;
  logic [NO_BANKS-1:0][PORT_W-1:0]   bank_sel;
  logic [NO_BANKS-1:0]               bank_en;
  logic [DATA_WIDTH-1:0]             bank_rdata [NO_BANKS];
  logic [STRB_WIDTH-1:0]             bank_rtag  [NO_BANKS];
  logic [NO_PORTS-1:0]               rvalid_q;
  logic [NO_PORTS-1:0][BANK_W-1:0]   resp_bank;
  logic [NO_PORTS-1:0][DATA_WIDTH-1:0] hold_data;
  logic [NO_PORTS-1:0][STRB_WIDTH-1:0] hold_tag;

  // Decode each port's byte address into bank and row.
  always_comb begin
    tgt_bank = '0;
    tgt_row  = '0;
    for (int p = 0; p < NO_PORTS; p++) begin
      tgt_bank[p] = BANK_W'(bank_of(64'(addr[p]), UA_W, NO_BANKS));
      tgt_row[p]  = ROW_W'(row_of(64'(addr[p]), UA_W, NO_BANKS, ROWS_L));
    end
  end

  // Per bank: first requesting port at or after rr_ptr, searched cyclically.
  always_comb begin
    logic found;
    found    = 1'b0;
    gnt      = '0;
    bank_en  = '0;
    bank_sel = '0;
    for (int b = 0; b < NO_BANKS; b++) begin
      found = 1'b0;
      for (int k = 0; k < NO_PORTS; k++) begin
        for (int p = 0; p < NO_PORTS; p++) begin
          if (!found && req[p] && (int'(tgt_bank[p]) == b) &&
              (((int'(rr_ptr[b]) + k) % NO_PORTS) == p)) begin
            found       = 1'b1;
            gnt[p]      = 1'b1;
            bank_en[b]  = 1'b1;
            bank_sel[b] = PORT_W'(p);
          end
        end
      end
    end
  end

  // Advance a bank's pointer past its winner; hold it when idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else begin
      for (int b = 0; b < NO_BANKS; b++) begin
        if (bank_en[b])
          rr_ptr[b] <= (bank_sel[b] == PORT_W'(NO_PORTS - 1)) ? '0 : bank_sel[b] + PORT_W'(1);
      end
    end
  end

  for (genvar b = 0; b < NO_BANKS; b++) begin : g_bank
    // Writes are blocked while reset is asserted.
    adam_mem_bank #(
      .ROWS       (ROWS_L),
      .ROW_W      (ROW_W),
      .DATA_WIDTH (DATA_WIDTH),
      .STRB_WIDTH (STRB_WIDTH)
    ) u_bank (
      .clk       (clk),
      .en        (bank_en[b] & rst_n),
      .row       (tgt_row[bank_sel[b]]),
      .we        (we[bank_sel[b]]),
      .be        (be[bank_sel[b]]),
      .wdata     (wdata[bank_sel[b]]),
      .we_tag    (we_tag[bank_sel[b]]),
      .wdata_tag (wdata_tag[bank_sel[b]]),
      .rdata     (bank_rdata[b]),
      .rdata_tag (bank_rtag[b])
    );
  end

  // Response valid one cycle after grant; capture delivered data for holding.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid_q  <= '0;
      hold_data <= '0;
      hold_tag  <= '0;
    end else begin
      rvalid_q <= gnt;
      for (int p = 0; p < NO_PORTS; p++) begin
        if (rvalid_q[p]) begin
          hold_data[p] <= bank_rdata[resp_bank[p]];
          hold_tag[p]  <= bank_rtag[resp_bank[p]];
        end
      end
    end
  end

  // Remember which bank will answer each port's outstanding access.
  always_ff @(posedge clk) begin
    for (int p = 0; p < NO_PORTS; p++) begin
      if (gnt[p]) resp_bank[p] <= tgt_bank[p];
    end
  end

  // Live bank data during the response cycle, held copy otherwise.
  always_comb begin
    rvalid    = rvalid_q;
    rdata     = hold_data;
    rdata_tag = hold_tag;
    for (int p = 0; p < NO_PORTS; p++) begin
      if (rvalid_q[p]) begin
        rdata[p]     = bank_rdata[resp_bank[p]];
        rdata_tag[p] = bank_rtag[resp_bank[p]];
      end
    end
  end

endmodule
